// File: rtl/serial_add_arb.sv
// Round-robin arbiter that time-shares one bit-serial full adder (two half
// adders plus a carry flop) between two requesters, LSB-first over WIDTH cycles.
module serial_add_arb #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             ack0,
   output logic             ack1,
   output logic             done,
   output logic             busy,
   output logic             gnt_id,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             c_q, c_d;
   logic             cout_q, cout_d;
   logic             gnt_id_q, gnt_id_d;
   logic             last_gnt_q, last_gnt_d;
   logic             ack0_q, ack0_d;
   logic             ack1_q, ack1_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;

   logic [1:0]       ha1_s, ha2_s;
   logic             c_next_s, win_s;
   logic [WIDTH-1:0] s_msb_s, acc_next_s;

   // Returns {carry, sum} of a single half-adder cell.
   function automatic logic [1:0] half_add(input logic x, input logic y);
      return {x & y, x ^ y};
   endfunction

   // Next-state, datapath and registered-output computation.
   always_comb begin
      state_d    = state_q;
      a_sh_d     = a_sh_q;
      b_sh_d     = b_sh_q;
      acc_d      = acc_q;
      sum_d      = sum_q;
      cnt_d      = cnt_q;
      c_d        = c_q;
      cout_d     = cout_q;
      gnt_id_d   = gnt_id_q;
      last_gnt_d = last_gnt_q;
      ack0_d     = 1'b0;
      ack1_d     = 1'b0;
      done_d     = 1'b0;
      busy_d     = busy_q;

      ha1_s    = half_add(a_sh_q[0], b_sh_q[0]);
      ha2_s    = half_add(ha1_s[0], c_q);
      c_next_s = ha1_s[1] | ha2_s[1];
      s_msb_s  = '0;
      s_msb_s[WIDTH-1] = ha2_s[0];
      acc_next_s = (acc_q >> 1'b1) | s_msb_s;

      // On a tie the pointer hands the grant to whoever was not served last.
      if (req0 && req1) begin
         win_s = ~last_gnt_q;
      end else begin
         win_s = ~req0;
      end

      case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               state_d    = S_RUN;
               a_sh_d     = win_s ? a1 : a0;
               b_sh_d     = win_s ? b1 : b0;
               acc_d      = '0;
               c_d        = 1'b0;
               cnt_d      = '0;
               gnt_id_d   = win_s;
               last_gnt_d = win_s;
               busy_d     = 1'b1;
            end else begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end
         end
         S_RUN: begin
            a_sh_d = a_sh_q >> 1'b1;
            b_sh_d = b_sh_q >> 1'b1;
            acc_d  = acc_next_s;
            c_d    = c_next_s;
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = S_DONE;
               sum_d   = acc_next_s;
               cout_d  = c_next_s;
               ack0_d  = ~gnt_id_q;
               ack1_d  = gnt_id_q;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         a_sh_q     <= '0;
         b_sh_q     <= '0;
         acc_q      <= '0;
         sum_q      <= '0;
         cnt_q      <= '0;
         c_q        <= 1'b0;
         cout_q     <= 1'b0;
         gnt_id_q   <= 1'b0;
         last_gnt_q <= 1'b1;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_sh_q     <= a_sh_d;
         b_sh_q     <= b_sh_d;
         acc_q      <= acc_d;
         sum_q      <= sum_d;
         cnt_q      <= cnt_d;
         c_q        <= c_d;
         cout_q     <= cout_d;
         gnt_id_q   <= gnt_id_d;
         last_gnt_q <= last_gnt_d;
         ack0_q     <= ack0_d;
         ack1_q     <= ack1_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
      end
   end

   assign ack0   = ack0_q;
   assign ack1   = ack1_q;
   assign done   = done_q;
   assign busy   = busy_q;
   assign gnt_id = gnt_id_q;
   assign sum    = sum_q;
   assign cout   = cout_q;

endmodule

// File: tb/tb_serial_add_arb.sv
// Directed bench for serial_add_arb: WIDTH=8 scenarios plus an exhaustive
// WIDTH=4 sweep, checked against a queue of expected results.
module tb_serial_add_arb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       req0_8, req1_8, ack0_8, ack1_8, done_8, busy_8, gnt_8, cout_8;
   logic [7:0] a0_8, b0_8, a1_8, b1_8, sum_8;
   logic       req0_4, req1_4, ack0_4, ack1_4, done_4, busy_4, gnt_4, cout_4;
   logic [3:0] a0_4, b0_4, a1_4, b1_4, sum_4;

   serial_add_arb #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst),
      .req0(req0_8), .a0(a0_8), .b0(b0_8),
      .req1(req1_8), .a1(a1_8), .b1(b1_8),
      .ack0(ack0_8), .ack1(ack1_8), .done(done_8), .busy(busy_8),
      .gnt_id(gnt_8), .sum(sum_8), .cout(cout_8)
   );

   serial_add_arb #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst),
      .req0(req0_4), .a0(a0_4), .b0(b0_4),
      .req1(req1_4), .a1(a1_4), .b1(b1_4),
      .ack0(ack0_4), .ack1(ack1_4), .done(done_4), .busy(busy_4),
      .gnt_id(gnt_4), .sum(sum_4), .cout(cout_4)
   );

   typedef struct {
      logic       id;
      logic [7:0] sum;
      logic       cout;
   } exp_t;

   exp_t       exp_q[$];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] last_sum8, last_sum4;
   logic       last_c8, last_c4;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input bit sel4, input logic id, input logic v,
                          input logic [7:0] a, input logic [7:0] b);
      case ({sel4, id})
         2'b00: begin req0_8 = v; a0_8 = a; b0_8 = b; end
         2'b01: begin req1_8 = v; a1_8 = a; b1_8 = b; end
         2'b10: begin req0_4 = v; a0_4 = a[3:0]; b0_4 = b[3:0]; end
         default: begin req1_4 = v; a1_4 = a[3:0]; b1_4 = b[3:0]; end
      endcase
   endtask

   task automatic push(input bit sel4, input logic id, input logic [7:0] a, input logic [7:0] b);
      logic [8:0] t;
      exp_t       e;
      e.id = id;
      if (sel4) begin
         t      = {5'b0, a[3:0]} + {5'b0, b[3:0]};
         e.sum  = {4'b0, t[3:0]};
         e.cout = t[4];
      end else begin
         t      = {1'b0, a} + {1'b0, b};
         e.sum  = t[7:0];
         e.cout = t[8];
      end
      exp_q.push_back(e);
   endtask

   // Advance from cycle cyc0 until an ack; busy must equal (cycle > lead).
   task automatic await_ack(input bit sel4, input int cyc0, input int lead, input int exp_cyc);
      int         cyc;
      bit         got;
      exp_t       e;
      logic       a0o, a1o, dno, bzo, gio, coo;
      logic [7:0] smo;
      cyc = cyc0;
      got = 1'b0;
      while (!got && cyc < exp_cyc + 5) begin
         @(negedge clk);
         cyc++;
         a0o = sel4 ? ack0_4 : ack0_8;
         a1o = sel4 ? ack1_4 : ack1_8;
         dno = sel4 ? done_4 : done_8;
         bzo = sel4 ? busy_4 : busy_8;
         gio = sel4 ? gnt_4 : gnt_8;
         coo = sel4 ? cout_4 : cout_8;
         smo = sel4 ? {4'b0, sum_4} : sum_8;
         chk("busy", bzo, (cyc > lead));
         if (a0o || a1o) begin
            got = 1'b1;
            chk("ack_exclusive", a0o & a1o, 1'b0);
            chk("done_pulse", dno, 1'b1);
            chk("ack_cycle", cyc, exp_cyc);
            if (exp_q.size() == 0) begin
               chk("scoreboard_underflow", exp_q.size(), 1);
            end else begin
               e = exp_q.pop_front();
               chk("ack_id", a1o, e.id);
               chk("gnt_id", gio, e.id);
               chk("sum", smo, e.sum);
               chk("cout", coo, e.cout);
               if (sel4) begin last_sum4 = e.sum; last_c4 = e.cout; end
               else begin last_sum8 = e.sum; last_c8 = e.cout; end
            end
         end else begin
            chk("done_low", dno, 1'b0);
            chk("sum_hold", smo, sel4 ? last_sum4 : last_sum8);
            chk("cout_hold", coo, sel4 ? last_c4 : last_c8);
         end
      end
      chk("ack_seen", got, 1'b1);
   endtask

   task automatic serve(input bit sel4, input logic id, input logic [7:0] a,
                        input logic [7:0] b, input bit scramble);
      int w;
      w = sel4 ? 4 : 8;
      set_req(sel4, id, 1'b1, a, b);
      push(sel4, id, a, b);
      if (scramble) begin
         @(negedge clk);
         set_req(sel4, id, 1'b1, ~a, ~b);
         await_ack(sel4, 1, 0, w + 1);
      end else begin
         await_ack(sel4, 0, 0, w + 1);
      end
      set_req(sel4, id, 1'b0, 8'h00, 8'h00);
      @(negedge clk);
      chk("idle_busy", sel4 ? busy_4 : busy_8, 1'b0);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      last_sum8 = 8'h00; last_c8 = 1'b0;
      last_sum4 = 8'h00; last_c4 = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      req0_8 = 1'b0; req1_8 = 1'b0; a0_8 = 8'h00; b0_8 = 8'h00; a1_8 = 8'h00; b1_8 = 8'h00;
      req0_4 = 1'b0; req1_4 = 1'b0; a0_4 = 4'h0; b0_4 = 4'h0; a1_4 = 4'h0; b1_4 = 4'h0;
      last_sum8 = 8'h00; last_c8 = 1'b0; last_sum4 = 8'h00; last_c4 = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_ack0", ack0_8, 1'b0);
      chk("rst_ack1", ack1_8, 1'b0);
      chk("rst_done", done_8, 1'b0);
      chk("rst_busy", busy_8, 1'b0);
      chk("rst_gnt", gnt_8, 1'b0);
      chk("rst_sum", sum_8, 8'h00);
      chk("rst_cout", cout_8, 1'b0);
      chk("rst_sum4", sum_4, 4'h0);

      // Single request, then overflow cases on requester 1.
      serve(1'b0, 1'b0, 8'h0F, 8'h01, 1'b0);
      serve(1'b0, 1'b1, 8'hFF, 8'h01, 1'b0);
      serve(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0);

      // Tie right after reset: requester 0 first, 1 next.
      pulse_reset();
      chk("rst2_sum", sum_8, 8'h00);
      chk("rst2_cout", cout_8, 1'b0);
      set_req(1'b0, 1'b0, 1'b1, 8'h12, 8'h34);
      set_req(1'b0, 1'b1, 1'b1, 8'h80, 8'h90);
      push(1'b0, 1'b0, 8'h12, 8'h34);
      push(1'b0, 1'b1, 8'h80, 8'h90);
      await_ack(1'b0, 0, 0, 9);
      set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      await_ack(1'b0, 9, 10, 19);
      set_req(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      @(negedge clk);
      chk("tie_idle_busy", busy_8, 1'b0);

      // Continuous contention: strict alternation, 10 cycles apart.
      set_req(1'b0, 1'b0, 1'b1, 8'hC3, 8'h5A);
      set_req(1'b0, 1'b1, 1'b1, 8'h77, 8'h99);
      for (int k = 0; k < 3; k++) begin
         push(1'b0, 1'b0, 8'hC3, 8'h5A);
         push(1'b0, 1'b1, 8'h77, 8'h99);
      end
      await_ack(1'b0, 0, 0, 9);
      for (int k = 1; k < 6; k++) begin
         await_ack(1'b0, 0, 1, 10);
      end
      set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      set_req(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      @(negedge clk);
      chk("cont_idle_busy", busy_8, 1'b0);

      // Reset in cycle 4 aborts the transaction without an ack.
      set_req(1'b0, 1'b0, 1'b1, 8'h55, 8'hAA);
      repeat (4) @(negedge clk);
      chk("abort_busy_before", busy_8, 1'b1);
      set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      pulse_reset();
      chk("abort_sum", sum_8, 8'h00);
      chk("abort_cout", cout_8, 1'b0);
      chk("abort_busy", busy_8, 1'b0);
      chk("abort_ack0", ack0_8, 1'b0);
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         chk("abort_noack", ack0_8 | done_8, 1'b0);
      end
      serve(1'b0, 1'b0, 8'h55, 8'hAA, 1'b0);

      // Exhaustive WIDTH=4 sweep, operands scrambled mid-RUN.
      for (int i = 0; i < 256; i++) begin
         logic [7:0] iv;
         iv = i[7:0];
         serve(1'b1, iv[0], {4'h0, iv[7:4]}, {4'h0, iv[3:0]}, 1'b1);
      end

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
